instr_loader: RTL and testbench

Program loader for the 5-stage MIPS core: accepts a stream of symbolic instructions (mnemonic code plus fields) over a valid/ready handshake, encodes each into a 32-bit MIPS word, and writes it into instruction memory at consecutive word addresses. It is the encoder counterpart of the decode-stage control unit and covers exactly the same instruction set: add, sub, and, or, xor, nor, slt, sll, srl, addi, andi, ori, xori, lw, sw, beq, j, nop. It holds the CPU in reset for the whole load, from start until done.

---
 rtl/instr_pkg.sv | 81 ++++++++
 rtl/instr_encode.sv | 40 ++++
 rtl/instr_loader.sv | 147 ++++++++++++++
 tb/tb_instr_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared MIPS instruction constants and field layout, used by the program
// loader's encoder and the decode-stage control unit.
package instr_pkg;

    localparam int unsigned MNEM_W = 5;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned TGT_W  = 26;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned FN_W   = 6;
    localparam int unsigned WORD_W = 32;

    localparam logic [MNEM_W-1:0] MN_NOP  = 5'd0;
    localparam logic [MNEM_W-1:0] MN_ADD  = 5'd1;
    localparam logic [MNEM_W-1:0] MN_SUB  = 5'd2;
    localparam logic [MNEM_W-1:0] MN_AND  = 5'd3;
    localparam logic [MNEM_W-1:0] MN_OR   = 5'd4;
    localparam logic [MNEM_W-1:0] MN_XOR  = 5'd5;
    localparam logic [MNEM_W-1:0] MN_NOR  = 5'd6;
    localparam logic [MNEM_W-1:0] MN_SLT  = 5'd7;
    localparam logic [MNEM_W-1:0] MN_SLL  = 5'd8;
    localparam logic [MNEM_W-1:0] MN_SRL  = 5'd9;
    localparam logic [MNEM_W-1:0] MN_ADDI = 5'd10;
    localparam logic [MNEM_W-1:0] MN_ANDI = 5'd11;
    localparam logic [MNEM_W-1:0] MN_ORI  = 5'd12;
    localparam logic [MNEM_W-1:0] MN_XORI = 5'd13;
    localparam logic [MNEM_W-1:0] MN_LW   = 5'd14;
    localparam logic [MNEM_W-1:0] MN_SW   = 5'd15;
    localparam logic [MNEM_W-1:0] MN_BEQ  = 5'd16;
    localparam logic [MNEM_W-1:0] MN_J    = 5'd17;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_XOR = 6'b100110;
    localparam logic [FN_W-1:0] FN_NOR = 6'b100111;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FN_W-1:0] FN_SLL = 6'b000000;
    localparam logic [FN_W-1:0] FN_SRL = 6'b000010;

    typedef struct packed {
        logic [MNEM_W-1:0] mnem;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  shamt;
        logic [IMM_W-1:0]  imm;
        logic [TGT_W-1:0]  target;
    } instr_fields_t;

    function automatic logic [WORD_W-1:0] enc_r(input logic [REG_W-1:0] rs,
                                                input logic [REG_W-1:0] rt,
                                                input logic [REG_W-1:0] rd,
                                                input logic [REG_W-1:0] shamt,
                                                input logic [FN_W-1:0]  fn);
        return {OP_RTYPE, rs, rt, rd, shamt, fn};
    endfunction

    function automatic logic [WORD_W-1:0] enc_i(input logic [OP_W-1:0]  op,
                                                input logic [REG_W-1:0] rs,
                                                input logic [REG_W-1:0] rt,
                                                input logic [IMM_W-1:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [WORD_W-1:0] enc_j(input logic [TGT_W-1:0] target);
        return {OP_J, target};
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: symbolic instruction fields to a 32-bit MIPS word.
// Illegal mnemonics encode as nop and raise illegal_c.
module instr_encode
    import instr_pkg::*;
(
    input  instr_fields_t      fields,
    output logic [WORD_W-1:0]  word_c,
    output logic               illegal_c
);

    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // Shifts ignore rs; every other R-type ignores shamt.
    always_comb begin
        word_c    = '0;
        illegal_c = 1'b0;
        case (fields.mnem)
            MN_NOP:  word_c = '0;
            MN_ADD:  word_c = enc_r(fields.rs, fields.rt, fields.rd, ZERO_REG, FN_ADD);
            MN_SUB:  word_c = enc_r(fields.rs, fields.rt, fields.rd, ZERO_REG, FN_SUB);
            MN_AND:  word_c = enc_r(fields.rs, fields.rt, fields.rd, ZERO_REG, FN_AND);
            MN_OR:   word_c = enc_r(fields.rs, fields.rt, fields.rd, ZERO_REG, FN_OR);
            MN_XOR:  word_c = enc_r(fields.rs, fields.rt, fields.rd, ZERO_REG, FN_XOR);
            MN_NOR:  word_c = enc_r(fields.rs, fields.rt, fields.rd, ZERO_REG, FN_NOR);
            MN_SLT:  word_c = enc_r(fields.rs, fields.rt, fields.rd, ZERO_REG, FN_SLT);
            MN_SLL:  word_c = enc_r(ZERO_REG, fields.rt, fields.rd, fields.shamt, FN_SLL);
            MN_SRL:  word_c = enc_r(ZERO_REG, fields.rt, fields.rd, fields.shamt, FN_SRL);
            MN_ADDI: word_c = enc_i(OP_ADDI, fields.rs, fields.rt, fields.imm);
            MN_ANDI: word_c = enc_i(OP_ANDI, fields.rs, fields.rt, fields.imm);
            MN_ORI:  word_c = enc_i(OP_ORI,  fields.rs, fields.rt, fields.imm);
            MN_XORI: word_c = enc_i(OP_XORI, fields.rs, fields.rt, fields.imm);
            MN_LW:   word_c = enc_i(OP_LW,   fields.rs, fields.rt, fields.imm);
            MN_SW:   word_c = enc_i(OP_SW,   fields.rs, fields.rt, fields.imm);
            MN_BEQ:  word_c = enc_i(OP_BEQ,  fields.rs, fields.rt, fields.imm);
            MN_J:    word_c = enc_j(fields.target);
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Program loader: encodes a handshaked stream of symbolic instructions into
// consecutive instruction-memory words while holding the CPU in reset.
module instr_loader
    import instr_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          in_mnem,
    input  logic [4:0]          in_rs,
    input  logic [4:0]          in_rt,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_shamt,
    input  logic [15:0]         in_imm,
    input  logic [25:0]         in_target,
    input  logic                in_last,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] addr_ctr_q,   addr_ctr_d;
    logic              wrap_q,       wrap_d;
    logic              in_ready_q,   in_ready_d;
    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_hold_q,   cpu_hold_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;
    logic [CNT_W-1:0]  count_q,      count_d;

    instr_fields_t fields_c;
    logic [31:0]   word_c;
    logic          illegal_c;
    logic          accept_c;

    assign fields_c = '{mnem: in_mnem, rs: in_rs, rt: in_rt, rd: in_rd,
                        shamt: in_shamt, imm: in_imm, target: in_target};
    assign accept_c = in_valid && in_ready_q;

    instr_encode u_encode (
        .fields    (fields_c),
        .word_c    (word_c),
        .illegal_c (illegal_c)
    );

    // Next state; wrap_q marks that the top address has been written.
    always_comb begin
        state_d      = state_q;
        addr_ctr_d   = addr_ctr_q;
        wrap_d       = wrap_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        err_d        = err_q;
        count_d      = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    addr_ctr_d = BASE_A;
                    wrap_d     = 1'b0;
                    count_d    = '0;
                    err_d      = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept_c) begin
                    if (wrap_q) begin
                        err_d = 1'b1;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = addr_ctr_q;
                        imem_wdata_d = word_c;
                        addr_ctr_d   = addr_ctr_q + ADDR_W'(1);
                        count_d      = count_q + CNT_W'(1);
                        if (addr_ctr_q == '1) wrap_d = 1'b1;
                        if (illegal_c) err_d = 1'b1;
                    end
                    if (in_last) state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_LOAD);
        cpu_hold_d = (state_d == S_LOAD) || (state_d == S_FIN);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_ctr_q   <= BASE_A;
            wrap_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_A;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_ctr_q   <= addr_ctr_d;
            wrap_q       <= wrap_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
            count_q      <= count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: one instance with ADDR_W=8 and one with
// ADDR_W=2 share all inputs; both are checked against a reference encoder.
module tb_instr_loader;

    logic clk = 1'b0;
    logic rst;
    logic start, in_valid, in_last;
    logic [4:0]  in_mnem, in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        rdy8, we8, hold8, done8, err8;
    logic [7:0]  addr8;
    logic [31:0] wd8;
    logic [8:0]  cnt8;
    logic        rdyo, weo, holdo, doneo, erro;
    logic [1:0]  addro;
    logic [31:0] wdo;
    logic [2:0]  cnto;

    always #5 clk = ~clk;

    instr_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy8),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8), .cpu_hold(hold8),
        .done(done8), .err(err8), .count(cnt8)
    );

    instr_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_ov (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdyo),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(weo), .imem_addr(addro), .imem_wdata(wdo), .cpu_hold(holdo),
        .done(doneo), .err(erro), .count(cnto)
    );

    typedef struct {
        int mnem; int rs; int rt; int rd; int shamt; int imm; int target;
        logic [31:0] exp; bit has_exp;
    } vec_t;

    typedef struct { int addr; logic [31:0] data; int cyc; } wr_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    wr_t wr8_q[$];
    wr_t wro_q[$];
    int  acc_q[$];
    vec_t prog[$];
    int done8_n, doneo_n, done8_cyc, doneo_cyc;
    logic hold_at_done;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we8) wr8_q.push_back('{int'(addr8), wd8, cyc});
        if (weo) wro_q.push_back('{int'(addro), wdo, cyc});
        if (done8) begin done8_n++; done8_cyc = cyc; hold_at_done = hold8; end
        if (doneo) begin doneo_n++; doneo_cyc = cyc; end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoder from the instruction-format tables, using plain arithmetic.
    function automatic logic [31:0] ref_enc(input vec_t v);
        longint fn_tab[9] = '{32, 34, 36, 37, 38, 39, 42, 0, 2};
        longint op_tab[7] = '{8, 12, 13, 14, 35, 43, 4};
        longint w = 0;
        if (v.mnem >= 1 && v.mnem <= 9) begin
            bit shift = (v.mnem >= 8);
            w = longint'(shift ? 0 : v.rs) * (2**21) + longint'(v.rt) * (2**16)
              + longint'(v.rd) * (2**11) + longint'(shift ? v.shamt : 0) * 64 + fn_tab[v.mnem-1];
        end else if (v.mnem >= 10 && v.mnem <= 16) begin
            w = op_tab[v.mnem-10] * (64'd1 << 26) + longint'(v.rs) * (2**21)
              + longint'(v.rt) * (2**16) + longint'(v.imm);
        end else if (v.mnem == 17) begin
            w = 2 * (64'd1 << 26) + longint'(v.target);
        end
        return 32'(w);
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.mnem   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(18, 31)) : int'($urandom_range(0, 17));
        v.rs     = int'($urandom_range(0, 31));
        v.rt     = int'($urandom_range(0, 31));
        v.rd     = int'($urandom_range(0, 31));
        v.shamt  = int'($urandom_range(0, 31));
        v.imm    = int'($urandom_range(0, 65535));
        v.target = int'($urandom_range(0, (1 << 26) - 1));
        v.exp    = '0;
        v.has_exp = 1'b0;
        return v;
    endfunction

    task automatic set_fields(input vec_t v);
        in_mnem = 5'(v.mnem); in_rs = 5'(v.rs); in_rt = 5'(v.rt); in_rd = 5'(v.rd);
        in_shamt = 5'(v.shamt); in_imm = 16'(v.imm); in_target = 26'(v.target);
    endtask

    task automatic check_dut(input int d);
        int n = prog.size();
        int cap = (d == 0) ? 256 : 4;
        int nexp = (n < cap) ? n : cap;
        int got = (d == 0) ? wr8_q.size() : wro_q.size();
        bit any_ill = (n > cap);
        wr_t w;
        foreach (prog[i]) if (prog[i].mnem > 17) any_ill = 1'b1;
        chk($sformatf("d%0d_nwrites", d), 64'(got), 64'(nexp));
        for (int k = 0; k < nexp && k < got; k++) begin
            w = (d == 0) ? wr8_q[k] : wro_q[k];
            chk($sformatf("d%0d_w%0d_addr", d, k), 64'(w.addr), 64'(k));
            chk($sformatf("d%0d_w%0d_data", d, k), 64'(w.data), 64'(ref_enc(prog[k])));
            chk($sformatf("d%0d_w%0d_latency", d, k), 64'(w.cyc), 64'(acc_q[k] + 1));
            if (prog[k].has_exp)
                chk($sformatf("d%0d_w%0d_const", d, k), 64'(w.data), 64'(prog[k].exp));
        end
        chk($sformatf("d%0d_count", d), (d == 0) ? 64'(cnt8) : 64'(cnto), 64'(nexp));
        chk($sformatf("d%0d_err", d), (d == 0) ? 64'(err8) : 64'(erro), 64'(any_ill));
        chk($sformatf("d%0d_done_cyc", d), (d == 0) ? 64'(done8_cyc) : 64'(doneo_cyc),
            64'(acc_q[n-1] + 2));
    endtask

    // Runs prog[] as one load; gaps in [gmin,gmax]; start re-pulsed with word start_at.
    task automatic run_prog(input int gmin, input int gmax, input int start_at);
        int n = prog.size();
        wr8_q.delete(); wro_q.delete(); acc_q.delete();
        done8_n = 0; doneo_n = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_after_start", 64'(rdy8), 64'd1);
        chk("hold_after_start", 64'(hold8), 64'd1);
        chk("err_cleared", 64'(err8), 64'd0);
        chk("count_cleared", 64'(cnt8), 64'd0);
        for (int i = 0; i < n; i++) begin
            int g = int'($urandom_range(gmax, gmin));
            repeat (g) begin
                in_valid = 1'b0;
                set_fields(rand_vec());
                @(posedge clk); #1;
                chk("ready_in_gap", 64'(rdy8), 64'd1);
            end
            set_fields(prog[i]);
            in_valid = 1'b1;
            in_last = (i == n - 1);
            start = (i == start_at);
            for (int t = 0; t < 5 && !rdy8; t++) begin @(posedge clk); #1; end
            acc_q.push_back(cyc);
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        for (int t = 0; t < 20 && done8_n == 0; t++) @(negedge clk);
        chk("done_seen", 64'(done8_n), 64'd1);
        if (done8_n != 0) begin
            chk("hold_low_at_done", 64'(hold_at_done), 64'd0);
            check_dut(0);
            check_dut(1);
        end
        @(posedge clk); #1;
        chk("idle_ready", 64'(rdy8), 64'd0);
        chk("idle_hold", 64'(hold8), 64'd0);
        chk("idle_done", 64'(done8), 64'd0);
    endtask

    vec_t tbl[13];
    int sz;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        set_fields(rand_vec());
        tbl = '{
            '{1,  1,  2, 3, 9, 0, 0, 32'h00221820, 1'b1},
            '{10, 0,  4, 0, 0, 5, 0, 32'h20040005, 1'b1},
            '{8,  7,  1, 2, 4, 0, 0, 32'h00011100, 1'b1},
            '{6,  5,  6, 7, 3, 0, 0, 32'h00A63827, 1'b1},
            '{25, 1,  2, 3, 4, 16'h1234, 0, 32'h00000000, 1'b1},
            '{16, 1,  2, 0, 0, 16'hFFFF, 0, 32'h1022FFFF, 1'b1},
            '{2,  2,  3, 1, 5, 0, 0, 32'h00430822, 1'b1},
            '{14, 29, 8, 0, 0, 4, 0, 32'h8FA80004, 1'b1},
            '{9,  3,  5, 4, 1, 0, 0, 32'h00052042, 1'b1},
            '{12, 8,  9, 0, 0, 16'hABCD, 0, 32'h3509ABCD, 1'b1},
            '{15, 2,  1, 0, 0, 8, 0, 32'hAC410008, 1'b1},
            '{17, 0,  0, 0, 0, 0, 26'h3FFFFFF, 32'h0BFFFFFF, 1'b1},
            '{0,  31, 31, 31, 31, 16'hFFFF, 26'h3FFFFFF, 32'h00000000, 1'b1}
        };

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(rdy8), 64'd0);
        chk("rst_we", 64'(we8), 64'd0);
        chk("rst_addr", 64'(addr8), 64'd0);
        chk("rst_wdata", 64'(wd8), 64'd0);
        chk("rst_hold", 64'(hold8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_err", 64'(err8), 64'd0);
        chk("rst_count", 64'(cnt8), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Three-word program, back to back.
        prog.delete();
        prog.push_back(tbl[0]); prog.push_back(tbl[1]); prog.push_back(tbl[11]);
        prog[2].target = 0; prog[2].exp = 32'h08000000;
        run_prog(0, 0, -1);

        // Shift and branch with gaps between words.
        prog.delete();
        prog.push_back(tbl[2]); prog.push_back(tbl[5]);
        run_prog(2, 3, -1);

        // Table of encodings, illegal code mid-stream; overflows the narrow instance.
        prog.delete();
        foreach (tbl[i]) prog.push_back(tbl[i]);
        run_prog(0, 0, -1);

        // Single-word program, then start clears the sticky error.
        prog.delete();
        prog.push_back(tbl[3]);
        run_prog(0, 0, -1);

        // Six legal words: narrow instance writes 0..3 only.
        prog.delete();
        for (int i = 0; i < 6; i++) begin
            vec_t v = rand_vec();
            v.mnem = i + 1;
            prog.push_back(v);
        end
        run_prog(0, 1, -1);
        chk("ov_count", 64'(cnto), 64'd4);
        chk("ov_err", 64'(erro), 64'd1);

        // Start pulsed during LOAD is ignored; err from word 0 must survive.
        prog.delete();
        prog.push_back(tbl[4]);
        for (int i = 0; i < 4; i++) prog.push_back(tbl[i]);
        run_prog(0, 1, 2);

        for (int p = 0; p < 20; p++) begin
            int len = int'($urandom_range(1, 8));
            prog.delete();
            for (int i = 0; i < len; i++) prog.push_back(rand_vec());
            run_prog(0, 2, -1);
        end

        // Reset mid-load: outputs clear in the same cycle, no write afterwards.
        wr8_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_fields(tbl[i]);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(rdy8), 64'd0);
        chk("mid_rst_we", 64'(we8), 64'd0);
        chk("mid_rst_addr", 64'(addr8), 64'd0);
        chk("mid_rst_wdata", 64'(wd8), 64'd0);
        chk("mid_rst_hold", 64'(hold8), 64'd0);
        chk("mid_rst_count", 64'(cnt8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sz = wr8_q.size();
        chk("mid_rst_writes_before", 64'(sz), 64'd1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("mid_rst_no_ready", 64'(rdy8), 64'd0);
        end
        in_valid = 1'b0;
        chk("mid_rst_no_write", 64'(wr8_q.size()), 64'(sz));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
